// File: rtl/div_ctrl.sv
// div_ctrl: sequences one request at a time through an external sequential
// subtract-shift divider.
//
// Divide-by-zero and the signed MIN / -1 overflow case never reach the
// divider; their results are produced directly. Every other request runs the
// divider until it reports completion, or until TIMEOUT RUN cycles have
// passed. A timeout returns all-ones results with the error flag set.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            request handshake
//   in_sign                        1 = signed two's-complement division
//   in_dividend, in_divisor        request operands
//   out_valid / out_ready          result handshake
//   out_quotient, out_remainder    result
//   out_dbz, out_err               divide-by-zero / timeout flags
//   div_en, div_sign               divider enable and sign mode
//   div_dividend, div_divisor      registered operands driven to the divider
//   div_done                       divider finished (level, while div_en=1)
//   div_quotient, div_remainder    divider results
module div_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [DATA_W-1:0] in_dividend,
    input  logic [DATA_W-1:0] in_divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quotient,
    output logic [DATA_W-1:0] out_remainder,
    output logic              out_dbz,
    output logic              out_err,
    output logic              div_en,
    output logic              div_sign,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             is_dbz;
    logic             is_ovf;
    logic             bypass;
    logic             timeout_hit;
    logic             run_done;
    logic             run_timeout;

    assign accept = in_valid && (state == IDLE);
    assign is_dbz = (in_divisor == '0);
    // Signed MIN / -1 overflows the quotient, so it is answered here.
    assign is_ovf = in_sign && (in_dividend == MIN_NEG) && (in_divisor == ALL_ONES);
    assign bypass = is_dbz || is_ovf;

    // cnt holds the number of completed RUN cycles; the edge that would make
    // it TIMEOUT ends the wait, so RUN lasts at most TIMEOUT cycles.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // A finishing divider wins over a simultaneous timeout.
    assign run_done    = (state == RUN) && div_done;
    assign run_timeout = (state == RUN) && !div_done && timeout_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (div_done || timeout_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; div_en follows the registered state, so it rises the
    // cycle after accept and drops on the edge that leaves RUN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        div_en    = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     div_en    = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // RUN cycle counter, restarted on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered operands, held for the divider until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_sign     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (accept) begin
            div_sign     <= in_sign;
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
        end
    end

    // Result capture; values persist after DONE until the next capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_dbz       <= 1'b0;
            out_err       <= 1'b0;
        end else if (accept && is_dbz) begin
            out_quotient  <= ALL_ONES;
            out_remainder <= in_dividend;
            out_dbz       <= 1'b1;
            out_err       <= 1'b0;
        end else if (accept && is_ovf) begin
            out_quotient  <= MIN_NEG;
            out_remainder <= '0;
            out_dbz       <= 1'b0;
            out_err       <= 1'b0;
        end else if (run_done) begin
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_dbz       <= 1'b0;
            out_err       <= 1'b0;
        end else if (run_timeout) begin
            out_quotient  <= ALL_ONES;
            out_remainder <= ALL_ONES;
            out_dbz       <= 1'b0;
            out_err       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: a behavioural divider stub with programmable latency,
// table vectors, randomized requests against an arithmetic reference model,
// and hand sequences for stall, back-to-back, timeout and mid-RUN reset.
module tb_div_ctrl;

    localparam int DW   = 32;
    localparam int TOUT = 40;
    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign;
    logic [31:0] in_dividend, in_divisor;
    logic        out_valid, out_ready;
    logic [31:0] out_quotient, out_remainder;
    logic        out_dbz, out_err;
    logic        div_en, div_sign;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done;
    logic [31:0] div_quotient, div_remainder;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_W(DW), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dbz(out_dbz), .out_err(out_err),
        .div_en(div_en), .div_sign(div_sign),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Divider stub: raises div_done div_lat cycles into an enable window
    int dcnt = 0;
    int div_lat = 0;
    bit div_stub = 1'b0;

    always @(posedge clk) begin
        if (div_en !== 1'b1) dcnt <= 0;
        else if (dcnt < div_lat) dcnt <= dcnt + 1;
    end

    assign div_done = (div_en === 1'b1) && !div_stub && (dcnt == div_lat);

    always_comb begin
        div_quotient  = ONES;
        div_remainder = ONES;
        if (div_divisor != 32'd0) begin
            if (div_sign && div_dividend == MINV && div_divisor == ONES) begin
                div_quotient  = MINV;
                div_remainder = 32'd0;
            end else if (div_sign) begin
                div_quotient  = $signed(div_dividend) / $signed(div_divisor);
                div_remainder = $signed(div_dividend) % $signed(div_divisor);
            end else begin
                div_quotient  = div_dividend / div_divisor;
                div_remainder = div_dividend % div_divisor;
            end
        end
    end

    // Shortest div_en low run seen between two enable windows
    int low_run  = 0;
    int min_gap  = 1000;
    int n_gaps   = 0;
    bit seen_high = 1'b0;
    always @(negedge clk) begin
        if (div_en === 1'b1) begin
            if (seen_high && low_run > 0) begin
                n_gaps = n_gaps + 1;
                if (low_run < min_gap) min_gap = low_run;
            end
            seen_high = 1'b1;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
    end

    // Reference: results follow directly from the arithmetic rules
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dbz, output logic byp);
        dbz = 1'b0;
        byp = 1'b0;
        if (b == 32'd0) begin
            q = ONES; r = a; dbz = 1'b1; byp = 1'b1;
        end else if (s && a == MINV && b == ONES) begin
            q = MINV; r = 32'd0; byp = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_result(input string tag, output int edges, output int en_cyc);
        edges = 0;
        en_cyc = 0;
        while (out_valid !== 1'b1 && edges < TOUT + 20) begin
            if (div_en === 1'b1) en_cyc = en_cyc + 1;
            @(posedge clk); #1;
            edges = edges + 1;
        end
        if (out_valid !== 1'b1) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s out_valid never rose: actual=0 required=1", tag);
        end
    endtask

    task automatic release_out(input string tag);
        logic [31:0] q0;
        q0 = out_quotient;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " out_valid_after_ready"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready_after_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " quotient_kept"}, out_quotient, q0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input logic eerr, input logic byp);
        int edges, en_cyc, exp_lat;
        div_lat = lat;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_dividend = a; in_divisor = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sign = ~s; in_dividend = $urandom; in_divisor = $urandom;
        wait_result(tag, edges, en_cyc);
        exp_lat = eerr ? TOUT : (byp ? 0 : lat + 1);
        chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, " div_en_cycles"}, 32'(en_cyc), 32'(exp_lat));
        chk({tag, " quotient"}, out_quotient, eq);
        chk({tag, " remainder"}, out_remainder, er);
        chk({tag, " dbz"}, 32'(out_dbz), 32'(edbz));
        chk({tag, " err"}, 32'(out_err), 32'(eerr));
        chk({tag, " div_dividend"}, div_dividend, a);
        chk({tag, " div_divisor"}, div_divisor, b);
        chk({tag, " div_sign"}, 32'(div_sign), 32'(s));
        chk({tag, " div_en_in_done"}, 32'(div_en), 32'd0);
        chk({tag, " in_ready_in_done"}, 32'(in_ready), 32'd0);
        release_out(tag);
    endtask

    typedef struct {
        string       name;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        err;
        logic        byp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog expired: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, en_cyc;
        logic [31:0] eq, er;
        logic edbz, ebyp;

        vecs[0] = '{"u_100_7",      1'b0, 32'd100,      32'd7,        3, 32'd14,       32'd2,        1'b0, 1'b0, 1'b0};
        vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFFFFF9, 32'd2,        5, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"dbz_1234",     1'b0, 32'h1234,     32'd0,        2, ONES,         32'h1234,     1'b1, 1'b0, 1'b1};
        vecs[3] = '{"s_ovf",        1'b1, MINV,         ONES,         2, MINV,         32'd0,        1'b0, 1'b0, 1'b1};
        vecs[4] = '{"u_min_ones",   1'b0, MINV,         ONES,         0, 32'd0,        MINV,         1'b0, 1'b0, 1'b0};
        vecs[5] = '{"s_dbz_neg",    1'b1, 32'hFFFFFFF0, 32'd0,        1, ONES,         32'hFFFFFFF0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"u_ones_1",     1'b0, ONES,         32'd1,        7, ONES,         32'd0,        1'b0, 1'b0, 1'b0};
        vecs[7] = '{"s_100_m7",     1'b1, 32'd100,      32'hFFFFFFF9, 4, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
        in_dividend = '0; in_divisor = '0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst div_en", 32'(div_en), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst quotient", out_quotient, 32'd0);
        chk("rst remainder", out_remainder, 32'd0);
        chk("rst dbz", 32'(out_dbz), 32'd0);
        chk("rst err", 32'(out_err), 32'd0);
        chk("rst div_dividend", div_dividend, 32'd0);
        chk("rst div_divisor", div_divisor, 32'd0);
        chk("rst div_sign", 32'(div_sign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].sign, vecs[i].a, vecs[i].b, vecs[i].lat,
                   vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].err, vecs[i].byp);
        end

        // Randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          kind;
            kind = $urandom_range(0, 9);
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (kind == 0) b = 32'd0;
            if (kind == 1) begin s = 1'b1; a = MINV; b = ONES; end
            if (kind == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
            ref_div(s, a, b, eq, er, edbz, ebyp);
            run_op("rand", s, a, b, $urandom_range(0, 12), eq, er, edbz, 1'b0, ebyp);
        end

        // Stall with a pending request, then back-to-back second op
        div_lat = 3;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_dividend = 32'd1000; in_divisor = 32'd9;
        @(posedge clk); #1;
        in_dividend = 32'd77; in_divisor = 32'd7;
        wait_result("stall", edges, en_cyc);
        chk("stall quotient", out_quotient, 32'd111);
        chk("stall remainder", out_remainder, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall quotient_hold", out_quotient, 32'd111);
            chk("stall remainder_hold", out_remainder, 32'd1);
            chk("stall operand_hold", div_dividend, 32'd1000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b idle in_ready", 32'(in_ready), 32'd1);
        chk("b2b idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b div_en", 32'(div_en), 32'd1);
        chk("b2b div_dividend", div_dividend, 32'd77);
        wait_result("b2b", edges, en_cyc);
        chk("b2b quotient", out_quotient, 32'd11);
        chk("b2b remainder", out_remainder, 32'd0);
        release_out("b2b");

        // Divider that never finishes
        div_stub = 1'b1;
        run_op("timeout", 1'b0, 32'd50, 32'd5, 0, ONES, ONES, 1'b0, 1'b1, 1'b0);
        div_stub = 1'b0;
        run_op("after_timeout", 1'b0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);

        // Reset pulsed mid-RUN
        div_stub = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_dividend = 32'd500; in_divisor = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midrun div_en_before", 32'(div_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun rst div_en", 32'(div_en), 32'd0);
        chk("midrun rst out_valid", 32'(out_valid), 32'd0);
        chk("midrun rst div_dividend", div_dividend, 32'd0);
        chk("midrun rst quotient", out_quotient, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        div_stub = 1'b0;
        run_op("rst_6_3", 1'b0, 32'd6, 32'd3, 2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);

        chk("div_en_gap_seen", 32'(n_gaps > 0), 32'd1);
        chk("div_en_gap_min_ge2", 32'(min_gap >= 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
